// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
// OPMODE encodings, FSM states and default slice latencies.
package dsp48a1_pkg;

  localparam logic [7:0] OPM_ZERO = 8'h00;
  localparam logic [7:0] OPM_MUL  = 8'h01;
  localparam logic [7:0] OPM_MAC  = 8'h09;

  localparam int DEF_MULT_LAT = 2;
  localparam int DEF_P_LAT    = 1;
  localparam int DEF_OPM_DLY  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OPC_NONE,
    OPC_MUL,
    OPC_MAC
  } opc_t;

  function automatic logic [7:0] opm_of(input logic [1:0] c);
    logic [7:0] r;
    r = OPM_ZERO;
    if (c == OPC_MUL) r = OPM_MUL;
    if (c == OPC_MAC) r = OPM_MAC;
    return r;
  endfunction

endpackage

// File: rtl/dsp48a1_mac_sequencer_dsp_adv_delay.sv
// Advance-gated shift register: moves one slot only on i_adv,
// so its contents stay in step with a stallable slice pipeline.
module dsp_adv_delay #(
  parameter int W = 2,
  parameter int D = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_adv,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [D];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < D; i++) r_sr[i] <= '0;
    end else if (i_adv) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[D-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice as a signed 18x18 MAC engine:
// streams a job of operand pairs in, drains, returns the sum.
module dsp48a1_mac_sequencer
  import dsp48a1_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int P_LAT    = DEF_P_LAT,
  parameter int OPM_DLY  = DEF_OPM_DLY
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CE,
  input  logic [47:0]      dsp_P,
  output logic [47:0]      result,
  output logic             result_valid
);

  localparam logic [7:0] DRN = 8'(MULT_LAT + P_LAT);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_drn;
  logic [47:0]      r_result;
  logic             w_feed;
  logic             w_drain;
  logic             w_xfer;
  logic             w_last;
  logic             w_adv;
  logic [1:0]       w_code_d;
  logic [1:0]       w_code_q;

  assign w_feed  = (r_state == S_FEED);
  assign w_drain = (r_state == S_DRAIN);
  assign w_xfer  = w_feed && op_valid;
  assign w_last  = (r_cnt == r_len - 1'b1);
  assign w_adv   = w_xfer || w_drain;

  // Z=0 only for the first pair; drain slots carry MAC so P is kept.
  assign w_code_d = (w_feed && r_cnt == '0) ? OPC_MUL : OPC_MAC;

  dsp_adv_delay #(
    .W (2),
    .D (OPM_DLY)
  ) u_opm_dly (
    .i_clk (CLK),
    .i_rst (RST),
    .i_adv (w_adv),
    .i_d   (w_code_d),
    .o_q   (w_code_q)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = (len != '0) ? S_FEED : S_DONE;
      end
      S_FEED: begin
        if (w_xfer && w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drn == 8'd1) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_len <= '0;
      r_cnt <= '0;
      r_drn <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_len <= len;
        r_cnt <= '0;
      end
      if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_drn <= DRN;
      end
      if (w_drain) r_drn <= r_drn - 8'd1;
    end
  end

  // Captured on entry to DONE so it is valid together with done.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_result <= '0;
    end else if (r_state == S_IDLE && start && len == '0) begin
      r_result <= '0;
    end else if (w_drain && r_drn == 8'd1) begin
      r_result <= dsp_P;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign result_valid = done;
  assign op_ready     = w_feed;
  assign dsp_CE       = w_adv;
  assign dsp_A        = op_a;
  assign dsp_B        = op_b;
  assign dsp_OPMODE   = opm_of(w_code_q);
  assign result       = r_result;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer with a behavioural DSP48A1
// slice and a job-level reference model.
module tb_dsp48a1_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        op_valid = 1'b0;
  logic [17:0] op_a = '0;
  logic [17:0] op_b = '0;
  logic        busy, done, op_ready, dsp_CE, result_valid;
  logic [17:0] dsp_A, dsp_B;
  logic [7:0]  dsp_OPMODE;
  logic [47:0] dsp_P, result;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  dsp48a1_mac_sequencer #(.LEN_W(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .dsp_A        (dsp_A),
    .dsp_B        (dsp_B),
    .dsp_OPMODE   (dsp_OPMODE),
    .dsp_CE       (dsp_CE),
    .dsp_P        (dsp_P),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [47:0] prod(input logic [17:0] a,
                                       input logic [17:0] b);
    logic signed [47:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Behavioural DSP48A1 slice: A1/B1, M, OPMODE and P registers.
  logic signed [17:0] s_a1 = '0;
  logic signed [17:0] s_b1 = '0;
  logic signed [35:0] s_m  = '0;
  logic [7:0]         s_opm = '0;
  logic [47:0]        s_p  = '0;
  logic [47:0]        s_x, s_z;

  always_comb begin
    s_x = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
    s_z = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  end

  always @(posedge CLK) begin
    if (dsp_CE) begin
      s_a1  <= dsp_A;
      s_b1  <= dsp_B;
      s_m   <= s_a1 * s_b1;
      s_opm <= dsp_OPMODE;
      s_p   <= s_z + s_x;
    end
  end
  assign dsp_P = s_p;

  // Job-level model: pairs left, drain cycles left, running sum.
  bit          m_busy = 0, m_done = 0;
  int          m_left = 0, m_drain = 0;
  logic [47:0] m_sum = '0, m_result = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy = 0; m_done = 0; m_left = 0; m_drain = 0;
      m_sum = '0; m_result = '0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1;
        m_sum  = '0;
        if (len == 16'd0) begin
          m_done = 1;
          m_result = '0;
        end else begin
          m_left = int'(len);
        end
      end
    end else if (m_left > 0) begin
      if (op_valid) begin
        m_sum += prod(op_a, op_b);
        m_left--;
        if (m_left == 0) m_drain = 3;
      end
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin
        m_done = 1;
        m_result = m_sum;
      end
    end
  end

  always @(negedge CLK) begin
    bit e_rdy, e_ce;
    e_rdy = m_busy && !m_done && m_left > 0;
    e_ce  = (e_rdy && op_valid) ||
            (m_busy && !m_done && m_left == 0 && m_drain > 0);
    chk("busy", 48'(busy), 48'(m_busy));
    chk("done", 48'(done), 48'(m_done));
    chk("rvalid", 48'(result_valid), 48'(m_done));
    chk("op_ready", 48'(op_ready), 48'(e_rdy));
    chk("dsp_CE", 48'(dsp_CE), 48'(e_ce));
    chk("result", result, m_result);
    chk("dsp_A", 48'(dsp_A), 48'(op_a));
  end

  logic [17:0] ga [4];
  logic [17:0] gb [4];

  // Call at #1 after a rising edge; returns at #1 after the edge
  // that follows the done cycle.
  task automatic run_job(input int n, input bit stall, input bit poke,
                         output logic [47:0] res, output int lat,
                         output int ces, output int rdy);
    int s, idx;
    bit ph, pst, got;
    logic [47:0] pp;
    start = 1'b1;
    len = 16'(n);
    s = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
    idx = 0; ph = 1; pst = 0; got = 0;
    ces = 0; rdy = 0; res = '0; lat = -1; pp = '0;
    for (int k = 0; k < 100 && !got; k++) begin
      op_valid = (idx < n) && ph;
      op_a = ga[idx % 4];
      op_b = gb[idx % 4];
      start = poke && (k == 1);
      if (poke && k == 1) len = 16'd5;
      @(negedge CLK);
      if (pst) chk("p_hold", dsp_P, pp);
      pst = stall && op_ready && !op_valid;
      if (pst) begin
        chk("ce_stall", 48'(dsp_CE), 48'd0);
        pp = dsp_P;
      end
      if (dsp_CE) ces++;
      if (op_ready) rdy++;
      if (op_valid && op_ready) idx++;
      if (done) begin
        got = 1;
        res = result;
        lat = cyc - s;
      end
      if (stall) ph = !ph;
      @(posedge CLK); #1;
    end
    op_valid = 1'b0;
    start = 1'b0;
    if (!got) chk("timeout", 48'd0, 48'd1);
  endtask

  logic [47:0] res;
  int lat, ces, rdy;

  initial begin
    @(negedge CLK);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_ready", 48'(op_ready), 48'd0);
    chk("rst_ce", 48'(dsp_CE), 48'd0);
    chk("rst_opmode", 48'(dsp_OPMODE), 48'd0);
    chk("rst_result", result, 48'd0);
    #2 RST = 1'b0;
    @(posedge CLK); #1;

    ga = '{18'd1, 18'd2, 18'd3, 18'd4};
    gb = '{18'd2, 18'd2, 18'd2, 18'd2};
    run_job(4, 0, 0, res, lat, ces, rdy);
    chk("j1_res", res, 48'd20);
    chk("j1_lat", 48'(lat), 48'd8);
    chk("j1_ce", 48'(ces), 48'd7);
    chk("j1_rdy", 48'(rdy), 48'd4);

    ga = '{18'h3FFFD, 18'd0, 18'd0, 18'd0};
    gb = '{18'd5, 18'd0, 18'd0, 18'd0};
    run_job(1, 0, 0, res, lat, ces, rdy);
    chk("neg_res", res, 48'hFFFF_FFFF_FFF1);
    chk("neg_lat", 48'(lat), 48'd5);

    ga = '{18'd1, 18'd2, 18'd3, 18'd4};
    gb = '{18'd2, 18'd2, 18'd2, 18'd2};
    run_job(4, 1, 0, res, lat, ces, rdy);
    chk("stall_res", res, 48'd20);
    chk("stall_lat", 48'(lat), 48'd11);
    chk("stall_ce", 48'(ces), 48'd7);

    run_job(0, 0, 0, res, lat, ces, rdy);
    chk("z_res", res, 48'd0);
    chk("z_lat", 48'(lat), 48'd1);
    chk("z_rdy", 48'(rdy), 48'd0);
    chk("z_ce", 48'(ces), 48'd0);

    ga = '{18'd3, 18'd4, 18'd0, 18'd0};
    gb = '{18'd3, 18'd4, 18'd0, 18'd0};
    run_job(2, 0, 1, res, lat, ces, rdy);
    chk("b2b1_res", res, 48'd25);
    chk("b2b1_lat", 48'(lat), 48'd6);
    ga = '{18'd7, 18'd0, 18'd0, 18'd0};
    gb = '{18'd7, 18'd0, 18'd0, 18'd0};
    run_job(1, 0, 0, res, lat, ces, rdy);
    chk("b2b2_res", res, 48'd49);
    chk("b2b2_lat", 48'(lat), 48'd5);

    start = 1'b1;
    len = 16'd4;
    @(posedge CLK); #1;
    start = 1'b0;
    op_valid = 1'b1; op_a = 18'd5; op_b = 18'd5;
    @(posedge CLK); #1;
    op_a = 18'd6; op_b = 18'd6;
    @(posedge CLK); #1;
    op_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("mrst_busy", 48'(busy), 48'd0);
    chk("mrst_ready", 48'(op_ready), 48'd0);
    chk("mrst_result", result, 48'd0);
    chk("mrst_ce", 48'(dsp_CE), 48'd0);
    @(negedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    ga = '{18'd1, 18'd2, 18'd0, 18'd0};
    gb = '{18'd1, 18'd2, 18'd0, 18'd0};
    run_job(2, 0, 0, res, lat, ces, rdy);
    chk("post_rst_res", res, 48'd5);

    repeat (2) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dsp48a1_mac_sequencer.md
Name: dsp48a1_mac_sequencer

Overview:
Sequences one DSP48A1 slice (A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT") as a signed 18x18 multiply-accumulate engine. It accepts a job of `len` operand pairs, streams them into the slice over a valid/ready interface and drives OPMODE and clock enables. It gates the slice pipeline on stalls, drains the pipeline and returns the 48-bit dot product. It sits between a job-issuing master and the DSP48A1 instance.

Parameters:
LEN_W, 16, width of job length / pair counter
MULT_LAT, 2, advances from A/B port to M register output (A1REG+MREG)
P_LAT, 1, advances from M to P output (PREG)
OPM_DLY, 1, advances by which OPMODE leads M-stage alignment (must be >=1, < MULT_LAT+P_LAT)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
start  in  1  job request, sampled only in IDLE
len  in  LEN_W  number of operand pairs, sampled with start
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse, job complete
op_valid  in  1  operand pair valid
op_ready  out  1  sequencer accepts pair (high only in FEED)
op_a  in  18  signed multiplicand
op_b  in  18  signed multiplier
dsp_A  out  18  to DSP48A1 A (= op_a, combinational)
dsp_B  out  18  to DSP48A1 B (= op_b, combinational)
dsp_OPMODE  out  8  to DSP48A1 OPMODE
dsp_CE  out  1  drives CEA, CEB, CEM, CEP, CEOPMODE together
dsp_P  in  48  from DSP48A1 P
result  out  48  dot product, held until next done
result_valid  out  1  equals done

Behaviour:
- Reset (async, RST=1): state=IDLE; busy, done, result_valid, op_ready, dsp_CE = 0; result=0; pair counter, drain counter and OPMODE delay line = 0; dsp_OPMODE=8'h00. Reset mid-job abandons the job. No done is issued for it.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 and len!=0 -> latch len, FEED. start=1 and len==0 -> DONE with result forced to 0 (dsp_P not read). start while not IDLE is ignored.
- FEED: op_ready=1. A transfer occurs when op_valid && op_ready. Each transfer is one pipeline advance: dsp_CE=1 that cycle. No transfer means dsp_CE=0 and the whole slice freezes. The accumulator and in-flight products are preserved.
- OPMODE per pair: first pair of job uses OPM_MUL=8'h01 (X=M, Z=0). Later pairs use OPM_MAC=8'h09 (X=M, Z=P). No pre-adder, carry or subtract.
- The first-flag passes through an OPM_DLY-deep delay line that shifts only on advance. dsp_OPMODE is derived from the delay-line output, so each OPMODE meets its own product at the post-adder.
- Last transfer (count==len-1) -> DRAIN with drain counter = MULT_LAT+P_LAT.
- DRAIN: dsp_CE=1 every cycle, decrement counter. On counter reaching 0 -> DONE. The delay line keeps shifting OPM_MAC-coded entries so the final accumulate is not disturbed.
- DONE (one cycle): result<=dsp_P (or 0 for len=0), result_valid=done=1, busy=1 -> IDLE next cycle.
- Latency with no stalls: done asserts len+MULT_LAT+P_LAT+1 cycles after the start cycle.
- Arithmetic: full signed 36-bit product sign-extended to 48 bits. Accumulation wraps modulo 2^48 inside the slice. The sequencer performs no saturation.
- Counter wrap: len up to 2^LEN_W-1 is supported; the counter never wraps within a job.

Decomposition:
- Package dsp48a1_pkg: OPM_MUL, OPM_MAC, OPM_ZERO constants; state enum typedef; default latency constants MULT_LAT/P_LAT.
- Sub-module dsp_adv_delay: advance-gated shift register (width, depth params) used for the first-flag/OPMODE alignment line.
- The top-level instantiates the sequencer with the DSP48A1 in a separate wrapper used by the bench.

Test Plan:
- len=4, a=1,2,3,4, b=2, op_valid always 1 -> result=48'd20, done exactly 8 cycles after start, dsp_CE high 7 cycles.
- len=1, a=-3 (18'h3FFFD), b=5 -> result=48'hFFFF_FFFF_FFF1 (-15).
- len=4 as first case with op_valid low every other cycle -> result still 20; dsp_CE=0 on every stall cycle; P unchanged across stalls.
- len=0 -> done one cycle after start, result=0, op_ready never asserted, dsp_CE never asserted.
- Back-to-back: job1 len=2 (3x3, 4x4 -> 25), job2 len=1 (7x7) started in cycle after done -> result 49, proving Z=0 on first pair; start pulsed during job1 busy is ignored.
- RST asserted mid-FEED after 2 of 4 transfers -> same cycle: busy=0, op_ready=0, result=0. Then a new job len=2 (1x1, 2x2) -> result=5.
